fp_div_round: RTL and testbench

Rounding and result stage placed directly downstream of the floating-point divider. It accepts one unrounded quotient per `done` pulse, meaning the packed sign, exponent, mantissa, round/sticky bits and exponent carry. It applies the IEEE-754 rounding mode and resolves overflow, underflow, invalid and divide-by-zero cases. It then delivers the final encoded result and exception flags through a 2-stage valid/ready pipeline to the writeback path.

---
 rtl/fp_div_round.sv | 180 ++++++++++++++++++
 tb/tb_fp_div_round.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fp_div_round.sv
// Rounding and result stage behind the FP divider: applies the IEEE-754 rounding
// mode, resolves specials/overflow/underflow, and drains through a 2-stage valid/ready pipe.
package fp_div_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2} fp_format_e;

  localparam int unsigned EXP_MAX  = 11;
  localparam int unsigned MANT_MAX = 52;

  function automatic int unsigned exp_bits(input fp_format_e f);
    case (f)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned mant_bits(input fp_format_e f);
    case (f)
      FP64:    return 52;
      FP16:    return 10;
      default: return 23;
    endcase
  endfunction

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  // Sized for the widest format; narrower formats use the low-order bits.
  typedef struct packed {
    logic                sign;
    logic [EXP_MAX-1:0]  exp;
    logic [MANT_MAX-1:0] mant;
  } fp_unrounded_t;

  typedef struct packed {
    fp_unrounded_t u_result;
    logic [1:0]    rs;
    logic          round_en;
    logic          invalid;
    logic [1:0]    exp_cout;
  } uround_res_t;
endpackage

module fp_div_round
  import fp_div_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  uround_res_t urnd_i,
  input  logic        dz_i,
  input  roundmode_e  rnd_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [fp_div_pkg::exp_bits(FP_FORMAT) + fp_div_pkg::mant_bits(FP_FORMAT):0] result_o,
  output logic [4:0]  flags_o
);
  localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT);
  localparam int unsigned MANT_WIDTH = mant_bits(FP_FORMAT);
  localparam int unsigned FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int unsigned SUM_WIDTH  = 2 + EXP_WIDTH + MANT_WIDTH;

  localparam logic [FP_WIDTH-2:0] INF   = {{EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  localparam logic [FP_WIDTH-2:0] MAXF  = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
  localparam logic [FP_WIDTH-1:0] R_IND = {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  logic                  s1_valid;
  logic                  s1_sign;
  logic [EXP_WIDTH-1:0]  s1_exp;
  logic [MANT_WIDTH-1:0] s1_mant;
  logic [1:0]            s1_rs;
  logic                  s1_invalid;
  logic [1:0]            s1_cout;
  logic                  s1_dz;
  roundmode_e            s1_rnd;
  logic                  s1_inc;

  logic                  s2_stall;
  logic                  inc_d;
  logic [SUM_WIDTH-1:0]  sum;
  logic [1:0]            sum_cout;
  logic [EXP_WIDTH-1:0]  sum_exp;
  logic [FP_WIDTH-2:0]  of_mag;
  logic [FP_WIDTH-1:0]  res_d;
  logic [4:0]            flags_d;
  logic                  unused_bits;

  // Upper struct bits only matter for wider formats.
  assign unused_bits = ^{urnd_i.u_result.exp, urnd_i.u_result.mant};

  assign s2_stall = valid_o && !ready_i;
  assign ready_o  = !s1_valid || !s2_stall;

  always_comb begin
    inc_d = 1'b0;
    case (rnd_i)
      RTZ:     inc_d = 1'b0;
      RDN:     inc_d = (urnd_i.rs[1] | urnd_i.rs[0]) & urnd_i.u_result.sign;
      RUP:     inc_d = (urnd_i.rs[1] | urnd_i.rs[0]) & ~urnd_i.u_result.sign;
      RMM:     inc_d = urnd_i.rs[1];
      default: inc_d = urnd_i.rs[1] & (urnd_i.rs[0] | urnd_i.u_result.mant[0]);
    endcase
    if (!urnd_i.round_en) inc_d = 1'b0;
  end

  // Mantissa carry ripples into exponent and exponent carry in one add.
  assign sum      = {s1_cout, s1_exp, s1_mant} + SUM_WIDTH'(s1_inc);
  assign sum_cout = sum[SUM_WIDTH-1 -: 2];
  assign sum_exp  = sum[EXP_WIDTH+MANT_WIDTH-1 -: EXP_WIDTH];

  always_comb begin
    of_mag = INF;
    case (s1_rnd)
      RTZ:     of_mag = MAXF;
      RDN:     of_mag = s1_sign ? INF : MAXF;
      RUP:     of_mag = s1_sign ? MAXF : INF;
      default: of_mag = INF;
    endcase
  end

  always_comb begin
    res_d   = {s1_sign, sum[EXP_WIDTH+MANT_WIDTH-1:0]};
    flags_d = {4'b0000, s1_rs[1] | s1_rs[0]};
    if (s1_invalid) begin
      res_d   = R_IND;
      flags_d = 5'b10000;
    end else if (s1_dz) begin
      res_d   = {s1_sign, INF};
      flags_d = 5'b01000;
    end else if (sum_cout[1]) begin
      res_d   = {s1_sign, {(FP_WIDTH-1){1'b0}}};
      flags_d = 5'b00011;
    end else if (sum_cout[0] || (&sum_exp)) begin
      res_d   = {s1_sign, of_mag};
      flags_d = 5'b00101;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      flags_o  <= '0;
    end else begin
      if (!s2_stall) begin
        valid_o <= s1_valid;
        if (s1_valid) begin
          result_o <= res_d;
          flags_o  <= flags_d;
        end
      end
      if (ready_o) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_sign    <= urnd_i.u_result.sign;
          s1_exp     <= urnd_i.u_result.exp[EXP_WIDTH-1:0];
          s1_mant    <= urnd_i.u_result.mant[MANT_WIDTH-1:0];
          s1_rs      <= urnd_i.rs;
          s1_invalid <= urnd_i.invalid;
          s1_cout    <= urnd_i.exp_cout;
          s1_dz      <= dz_i;
          s1_rnd     <= rnd_i;
          s1_inc     <= inc_d;
        end
      end
    end
  end

  a_no_accept_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (valid_i && !ready_o) |=> (s1_valid && $stable(s1_exp) && $stable(s1_mant) && $stable(s1_sign)));
endmodule

// File: tb/tb_fp_div_round.sv
// Directed-vector bench for fp_div_round (FP32): rounding modes, specials,
// latency, back-to-back streaming, backpressure and mid-flight reset.
module tb_fp_div_round;
  import fp_div_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  uround_res_t urnd_i;
  logic        dz_i;
  roundmode_e  rnd_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  int total = 0;
  int bad   = 0;

  fp_div_round #(.FP_FORMAT(FP32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .urnd_i(urnd_i), .dz_i(dz_i), .rnd_i(rnd_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [1:0]  rs;
    logic        round_en;
    logic        invalid;
    logic [1:0]  cout;
    logic        dz;
    logic [2:0]  rnd;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(string n, logic s, logic [7:0] e, logic [22:0] m, logic [1:0] rs,
                              logic en, logic inv, logic [1:0] c, logic dz, logic [2:0] rnd,
                              logic [31:0] r, logic [4:0] f);
    vec_t v;
    v.name = n; v.sign = s; v.exp = e; v.mant = m; v.rs = rs; v.round_en = en;
    v.invalid = inv; v.cout = c; v.dz = dz; v.rnd = rnd; v.exp_res = r; v.exp_flags = f;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    urnd_i                 = '0;
    urnd_i.u_result.sign   = v.sign;
    urnd_i.u_result.exp    = 11'(v.exp);
    urnd_i.u_result.mant   = 52'(v.mant);
    urnd_i.rs              = v.rs;
    urnd_i.round_en        = v.round_en;
    urnd_i.invalid         = v.invalid;
    urnd_i.exp_cout        = v.cout;
    dz_i                   = v.dz;
    rnd_i                  = roundmode_e'(v.rnd);
    valid_i                = 1'b1;
  endtask

  task automatic check_out(vec_t v, string tag);
    check({tag, "_valid_", v.name}, 32'(valid_o), 32'd1);
    check({tag, "_res_", v.name}, result_o, v.exp_res);
    check({tag, "_flags_", v.name}, 32'(flags_o), 32'(v.exp_flags));
  endtask

  task automatic single(vec_t v);
    @(negedge clk_i);
    drive(v);
    @(negedge clk_i);
    valid_i = 1'b0;
    check({"lat1_", v.name}, 32'(valid_o), 32'd0);
    @(negedge clk_i);
    check_out(v, "single");
    @(negedge clk_i);
    check({"drained_", v.name}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk("rne_carry",   0, 8'h7E, 23'h7FFFFF, 2'b10, 1, 0, 2'b00, 0, 3'd0, 32'h3F800000, 5'b00001);
    vecs[1]  = mk("rtz_trunc",   0, 8'h7E, 23'h7FFFFF, 2'b10, 1, 0, 2'b00, 0, 3'd1, 32'h3F7FFFFF, 5'b00001);
    vecs[2]  = mk("rne_tie_even",0, 8'h7E, 23'h000000, 2'b10, 1, 0, 2'b00, 0, 3'd0, 32'h3F000000, 5'b00001);
    vecs[3]  = mk("of_rne",      0, 8'hFE, 23'h7FFFFF, 2'b11, 1, 0, 2'b00, 0, 3'd0, 32'h7F800000, 5'b00101);
    vecs[4]  = mk("of_rtz",      0, 8'hFE, 23'h7FFFFF, 2'b11, 1, 0, 2'b00, 0, 3'd1, 32'h7F7FFFFF, 5'b00001);
    vecs[5]  = mk("rup_neg",     1, 8'hFE, 23'h7FFFFF, 2'b11, 1, 0, 2'b00, 0, 3'd3, 32'hFF7FFFFF, 5'b00001);
    vecs[6]  = mk("invalid",     0, 8'h00, 23'h000000, 2'b00, 1, 1, 2'b00, 0, 3'd0, 32'hFFC00000, 5'b10000);
    vecs[7]  = mk("dz_neg",      1, 8'h00, 23'h000000, 2'b00, 1, 0, 2'b00, 1, 3'd0, 32'hFF800000, 5'b01000);
    vecs[8]  = mk("uf_flush",    0, 8'h10, 23'h000005, 2'b00, 1, 0, 2'b11, 0, 3'd0, 32'h00000000, 5'b00011);
    vecs[9]  = mk("of_rdn_neg",  1, 8'hFE, 23'h7FFFFF, 2'b01, 1, 0, 2'b00, 0, 3'd2, 32'hFF800000, 5'b00101);
    vecs[10] = mk("cout_rtz_neg",1, 8'h10, 23'h000000, 2'b00, 1, 0, 2'b01, 0, 3'd1, 32'hFF7FFFFF, 5'b00101);
    vecs[11] = mk("rmm_neg",     1, 8'h80, 23'h000000, 2'b10, 1, 0, 2'b00, 0, 3'd4, 32'hC0000001, 5'b00001);
    vecs[12] = mk("round_dis",   0, 8'h80, 23'h000001, 2'b10, 0, 0, 2'b00, 0, 3'd0, 32'h40000001, 5'b00001);
    vecs[13] = mk("mode7_rne",   0, 8'h80, 23'h000001, 2'b10, 1, 0, 2'b00, 0, 3'd7, 32'h40000002, 5'b00001);
    vecs[14] = mk("exact",       0, 8'h80, 23'h000005, 2'b00, 1, 0, 2'b00, 0, 3'd0, 32'h40000005, 5'b00000);
    vecs[15] = mk("rup_of_pos",  0, 8'h10, 23'h000000, 2'b00, 1, 0, 2'b01, 0, 3'd3, 32'h7F800000, 5'b00101);

    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; urnd_i = '0; dz_i = 1'b0; rnd_i = RNE;
    repeat (3) @(negedge clk_i);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_result_o", result_o, 32'd0);
    check("rst_flags_o", 32'(flags_o), 32'd0);
    reset_i = 1'b0;

    for (int i = 0; i < 16; i++) single(vecs[i]);

    // Back-to-back stream: one result per cycle, no bubbles.
    for (int j = 0; j < 18; j++) begin
      @(negedge clk_i);
      if (j >= 2) check_out(vecs[j-2], "stream");
      check("stream_ready", 32'(ready_o), 32'd1);
      if (j < 16) drive(vecs[j]);
      else valid_i = 1'b0;
    end
    @(negedge clk_i);
    check("stream_end_valid", 32'(valid_o), 32'd0);

    // Backpressure: two accepted, third refused, drained in order.
    ready_i = 1'b0;
    drive(vecs[3]);
    @(negedge clk_i);
    check("bp_ready_2nd", 32'(ready_o), 32'd1);
    drive(vecs[11]);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("bp_ready_3rd", 32'(ready_o), 32'd0);
    check_out(vecs[3], "bp_hold0");
    repeat (3) @(negedge clk_i);
    check("bp_ready_held", 32'(ready_o), 32'd0);
    check_out(vecs[3], "bp_hold3");
    ready_i = 1'b1;
    #1 check("bp_ready_comb", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    check_out(vecs[11], "bp_drain");
    @(negedge clk_i);
    check("bp_empty", 32'(valid_o), 32'd0);

    // Reset with both stages full flushes everything.
    ready_i = 1'b0;
    drive(vecs[5]);
    @(negedge clk_i);
    drive(vecs[7]);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("full_ready_low", 32'(ready_o), 32'd0);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("mid_rst_valid_o", 32'(valid_o), 32'd0);
    check("mid_rst_ready_o", 32'(ready_o), 32'd1);
    check("mid_rst_result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    check("mid_rst_no_ghost", 32'(valid_o), 32'd0);
    ready_i = 1'b1;
    single(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
